// File: rtl/mips_multicycle.sv
// Multicycle MIPS subset core: FETCH/DECODE/EXEC/MEM/WB sequencing with an
// internal 32-entry register file and a word-addressed data memory.
module mips_multicycle #(
  parameter int DATA_W     = 32,
  parameter int DMEM_DEPTH = 64,
  parameter int PC_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instr,
  input  logic              instr_valid,
  output logic              instr_req,
  output logic [PC_W-1:0]   pc_out,
  output logic              retire,
  output logic [DATA_W-1:0] wb_data,
  output logic              illegal,
  output logic [2:0]        state
);

  localparam int AW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t                    state_q, state_d;
  logic [PC_W-1:0]           pc_q, pc_d;
  logic [31:0]               ir_q, ir_d;
  logic signed [DATA_W-1:0]  a_q, a_d, b_q, b_d;
  logic signed [DATA_W-1:0]  alu_q, alu_d, mdr_q, mdr_d, wb_q, wb_d;
  logic [AW-1:0]             addr_q, addr_d;
  logic                      illegal_q, illegal_d;
  logic [DATA_W-1:0]         rf_q   [32];
  logic [DATA_W-1:0]         dmem_q [DMEM_DEPTH];

  logic                      rf_we, dm_we, retire_c;
  logic [4:0]                rf_waddr;
  logic [DATA_W-1:0]         rf_wdata;

  logic [5:0]                op, fn;
  logic [4:0]                rs, rt, rd;
  logic signed [15:0]        imm16;
  logic signed [DATA_W-1:0]  imm;
  logic signed [PC_W-1:0]    br_off;
  logic [PC_W-1:0]           pc_inc;
  logic                      r_ok, legal;

  function automatic logic signed [DATA_W-1:0] alu_f(
    input logic [5:0]               opc,
    input logic [5:0]               fnc,
    input logic signed [DATA_W-1:0] x,
    input logic signed [DATA_W-1:0] y
  );
    logic signed [DATA_W-1:0] r;
    r = x + y;
    if (opc == OP_RTYPE) begin
      case (fnc)
        FN_SUB:  r = x - y;
        FN_AND:  r = x & y;
        FN_OR:   r = x | y;
        FN_SLT:  r = (x < y) ? DATA_W'(1) : '0;
        default: r = x + y;
      endcase
    end
    return r;
  endfunction

  assign op     = ir_q[31:26];
  assign fn     = ir_q[5:0];
  assign rs     = ir_q[25:21];
  assign rt     = ir_q[20:16];
  assign rd     = ir_q[15:11];
  assign imm16  = ir_q[15:0];
  assign imm    = DATA_W'(imm16);
  assign br_off = PC_W'(imm16);
  assign pc_inc = pc_q + PC_W'(1);
  assign r_ok   = (op == OP_RTYPE) &&
                  (fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT});
  assign legal  = r_ok || (op inside {OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J});

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    alu_d     = alu_q;
    mdr_d     = mdr_q;
    wb_d      = wb_q;
    addr_d    = addr_q;
    illegal_d = illegal_q;
    instr_req = 1'b0;
    retire_c  = 1'b0;
    rf_we     = 1'b0;
    rf_waddr  = rt;
    rf_wdata  = alu_q;
    dm_we     = 1'b0;
    case (state_q)
      S_FETCH: begin
        instr_req = 1'b1;
        if (instr_valid) begin
          ir_d    = instr;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d = (rs == 5'd0) ? '0 : rf_q[rs];
        b_d = (rt == 5'd0) ? '0 : rf_q[rt];
        if (legal) begin
          state_d = S_EXEC;
        end else begin
          illegal_d = 1'b1;
          state_d   = S_HALT;
        end
      end
      S_EXEC: begin
        if (op == OP_BEQ || op == OP_BNE) begin
          pc_d     = ((a_q == b_q) == (op == OP_BEQ)) ? pc_inc + br_off : pc_inc;
          retire_c = 1'b1;
          state_d  = S_FETCH;
        end else if (op == OP_J) begin
          pc_d     = {pc_inc[PC_W-1:26], ir_q[25:0]};
          retire_c = 1'b1;
          state_d  = S_FETCH;
        end else if (op == OP_LW || op == OP_SW) begin
          addr_d  = AW'(a_q + imm);
          state_d = S_MEM;
        end else begin
          alu_d   = alu_f(op, fn, a_q, (op == OP_ADDI) ? imm : b_q);
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (op == OP_SW) begin
          dm_we    = 1'b1;
          wb_d     = b_q;
          pc_d     = pc_inc;
          retire_c = 1'b1;
          state_d  = S_FETCH;
        end else begin
          mdr_d   = dmem_q[addr_q];
          state_d = S_WB;
        end
      end
      S_WB: begin
        rf_wdata = (op == OP_LW) ? mdr_q : alu_q;
        rf_waddr = (op == OP_RTYPE) ? rd : rt;
        rf_we    = (rf_waddr != 5'd0);
        wb_d     = rf_wdata;
        pc_d     = pc_inc;
        retire_c = 1'b1;
        state_d  = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  // Reset clears architectural state; rst also suppresses writes of the current instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      pc_q      <= '0;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_q     <= '0;
      mdr_q     <= '0;
      wb_q      <= '0;
      addr_q    <= '0;
      illegal_q <= 1'b0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
      for (int i = 0; i < DMEM_DEPTH; i++) dmem_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      alu_q     <= alu_d;
      mdr_q     <= mdr_d;
      wb_q      <= wb_d;
      addr_q    <= addr_d;
      illegal_q <= illegal_d;
      if (rf_we) rf_q[rf_waddr] <= rf_wdata;
      if (dm_we) dmem_q[addr_q] <= b_q;
    end
  end

  // wb_data shows the new value during the retire cycle, then holds it.
  assign retire  = retire_c & ~rst;
  assign wb_data = retire ? wb_d : wb_q;
  assign pc_out  = pc_q;
  assign illegal = illegal_q;
  assign state   = state_q;

endmodule

// File: tb/tb_mips_multicycle.sv
// Directed bench for mips_multicycle: instruction sequences with hand-computed
// results, latencies, PC values and reset/illegal behaviour.
module tb_mips_multicycle;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_req;
  logic [31:0] pc_out;
  logic        retire;
  logic [31:0] wb_data;
  logic        illegal;
  logic [2:0]  state;

  int checks;
  int errors;

  mips_multicycle #(.DATA_W(32), .DMEM_DEPTH(64), .PC_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_req   (instr_req),
    .pc_out      (pc_out),
    .retire      (retire),
    .wb_data     (wb_data),
    .illegal     (illegal),
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers one instruction in FETCH and waits (bounded) for its retire cycle.
  task automatic run_instr(input logic [31:0] ins, output int lat, output logic [31:0] wbv);
    instr       = ins;
    instr_valid = 1'b1;
    lat         = 1;
    while (retire !== 1'b1 && lat < 20) begin
      step();
      instr_valid = 1'b0;
      instr       = '0;
      lat++;
    end
    wbv = wb_data;
    step();
  endtask

  task automatic expect_instr(input string name, input logic [31:0] ins,
                              input int exp_lat, input logic [31:0] exp_wb);
    int          lat;
    logic [31:0] wbv;
    run_instr(ins, lat, wbv);
    checks++;
    if (lat !== exp_lat) begin
      errors++;
      $display("FAIL %s latency got %0d want %0d", name, lat, exp_lat);
    end
    checks++;
    if (wbv !== exp_wb) begin
      errors++;
      $display("FAIL %s wb_data got %h want %h", name, wbv, exp_wb);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; instr_valid = 1'b0; instr = '0;
    step(); step();
    checks++;
    if (state !== 3'd0 || pc_out !== 32'd0 || retire !== 1'b0 ||
        wb_data !== 32'd0 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got st=%0d pc=%h ret=%b wb=%h ill=%b want 0/0/0/0/0",
               state, pc_out, retire, wb_data, illegal);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (instr_req !== 1'b1) begin
      errors++;
      $display("FAIL reset_instr_req got %b want 1", instr_req);
    end
  endtask

  task automatic test_addi();
    expect_instr("addi_r1", 32'h20010005, 4, 32'd5);
    checks++;
    if (dut.rf_q[1] !== 32'd5 || pc_out !== 32'd1) begin
      errors++;
      $display("FAIL addi_state got r1=%h pc=%h want 5/1", dut.rf_q[1], pc_out);
    end
    expect_instr("addi_r2", 32'h20020007, 4, 32'd7);
  endtask

  task automatic test_alu();
    expect_instr("sub_r3", 32'h00221822, 4, 32'hFFFFFFFE);
    expect_instr("slt_r4", 32'h0060202A, 4, 32'd1);
    expect_instr("add_r6", 32'h00223020, 4, 32'd12);
    expect_instr("and_r7", 32'h00223824, 4, 32'd5);
    expect_instr("or_r8",  32'h00224025, 4, 32'd7);
    expect_instr("slt_r9_signed", 32'h0023482A, 4, 32'd0);
    expect_instr("add_r0", 32'h00220020, 4, 32'd12);
    checks++;
    if (dut.rf_q[0] !== 32'd0 || dut.rf_q[4] !== 32'd1 || pc_out !== 32'd9) begin
      errors++;
      $display("FAIL alu_regs got r0=%h r4=%h pc=%h want 0/1/9",
               dut.rf_q[0], dut.rf_q[4], pc_out);
    end
  endtask

  task automatic test_mem();
    expect_instr("sw_wrap", 32'hAC010041, 4, 32'd5);
    checks++;
    if (dut.dmem_q[1] !== 32'd5) begin
      errors++;
      $display("FAIL sw_wrap_dmem got %h want 5", dut.dmem_q[1]);
    end
    expect_instr("lw_r5", 32'h8C050001, 5, 32'd5);
    checks++;
    if (dut.rf_q[5] !== 32'd5) begin
      errors++;
      $display("FAIL lw_r5_reg got %h want 5", dut.rf_q[5]);
    end
  endtask

  task automatic test_branch();
    expect_instr("j_3", 32'h08000003, 3, 32'd5);
    checks++;
    if (pc_out !== 32'd3) begin errors++; $display("FAIL j_3_pc got %h want 3", pc_out); end
    expect_instr("beq_self", 32'h1000FFFF, 3, 32'd5);
    checks++;
    if (pc_out !== 32'd3) begin errors++; $display("FAIL beq_pc got %h want 3", pc_out); end
    expect_instr("bne_nt", 32'h14000004, 3, 32'd5);
    checks++;
    if (pc_out !== 32'd4) begin errors++; $display("FAIL bne_nt_pc got %h want 4", pc_out); end
    expect_instr("j_10", 32'h08000010, 3, 32'd5);
    checks++;
    if (pc_out !== 32'h10) begin errors++; $display("FAIL j_10_pc got %h want 10", pc_out); end
    expect_instr("bne_t", 32'h14200002, 3, 32'd5);
    checks++;
    if (pc_out !== 32'h13) begin errors++; $display("FAIL bne_t_pc got %h want 13", pc_out); end
  endtask

  task automatic test_idle();
    int bad;
    bad = 0;
    instr_valid = 1'b0;
    instr = 32'h20010063;
    for (int i = 0; i < 10; i++) begin
      step();
      if (state !== 3'd0 || retire !== 1'b0 || instr_req !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0 || pc_out !== 32'h13) begin
      errors++;
      $display("FAIL idle got bad_cycles=%0d pc=%h want 0/13", bad, pc_out);
    end
  endtask

  task automatic test_rst_in_mem();
    instr = 32'hAC010002; instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    step(); step();
    checks++;
    if (state !== 3'd3) begin errors++; $display("FAIL sw_in_mem state got %0d want 3", state); end
    rst = 1'b1;
    #1;
    checks++;
    if (retire !== 1'b0) begin errors++; $display("FAIL rst_mem_retire got %b want 0", retire); end
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (dut.dmem_q[2] !== 32'd0 || dut.rf_q[1] !== 32'd0 || state !== 3'd0 ||
        pc_out !== 32'd0 || wb_data !== 32'd0) begin
      errors++;
      $display("FAIL rst_mem_after got dmem2=%h r1=%h st=%0d pc=%h wb=%h want 0/0/0/0/0",
               dut.dmem_q[2], dut.rf_q[1], state, pc_out, wb_data);
    end
  endtask

  task automatic test_illegal();
    int seen;
    expect_instr("j_20", 32'h08000020, 3, 32'd0);
    foreach (dut.rf_q[i]) ;
    seen = 0;
    instr = 32'hFC000000; instr_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (retire === 1'b1) seen++;
      step();
      instr_valid = 1'b0;
    end
    checks++;
    if (illegal !== 1'b1 || state !== 3'd5 || instr_req !== 1'b0 ||
        seen != 0 || pc_out !== 32'h20) begin
      errors++;
      $display("FAIL illegal_op got ill=%b st=%0d req=%b retires=%0d pc=%h want 1/5/0/0/20",
               illegal, state, instr_req, seen, pc_out);
    end
    rst = 1'b1; step(); rst = 1'b0; #1;
    checks++;
    if (state !== 3'd0 || illegal !== 1'b0 || pc_out !== 32'd0) begin
      errors++;
      $display("FAIL illegal_clear got st=%0d ill=%b pc=%h want 0/0/0", state, illegal, pc_out);
    end
    seen = 0;
    instr = 32'h00221821; instr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (retire === 1'b1) seen++;
      step();
      instr_valid = 1'b0;
    end
    checks++;
    if (illegal !== 1'b1 || state !== 3'd5 || seen != 0) begin
      errors++;
      $display("FAIL illegal_funct got ill=%b st=%0d retires=%0d want 1/5/0", illegal, state, seen);
    end
    rst = 1'b1; step(); rst = 1'b0; #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    instr = '0;
    instr_valid = 1'b0;
    test_reset();
    test_addi();
    test_alu();
    test_mem();
    test_branch();
    test_idle();
    test_rst_in_mem();
    test_illegal();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
